mux2_arbiter_16: RTL

MUX2_ARBITER_16 -- requirements
Module: mux2_arbiter_16

---
 rtl/mux2_arbiter_16_pkg.sv | 20 ++
 rtl/Mux2x1_16.sv | 15 +
 rtl/mux2_arbiter_16.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mux2_arbiter_16_pkg.sv
// Shared types and defaults for the two-requester burst arbiter.
// Holds the FSM state encoding, the owner tag and the default sizes.
// No logic; imported by the arbiter top.
package mux2_arbiter_16_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_BURST = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

endpackage

// File: rtl/Mux2x1_16.sv
// Two-input word mux: o = s ? b : a.
// Latency: combinational.
// Backpressure: none, pure datapath.
module Mux2x1_16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] o
);

    assign o = s ? b : a;

endmodule

// File: rtl/mux2_arbiter_16.sv
// Burst-fair arbiter muxing requesters A/B into one registered output word.
// Latency: 1 cycle from grant to o/o_valid; owner switch costs 1 cycle.
// Backpressure: grants only when the output slot is empty or being consumed.
module mux2_arbiter_16
    import mux2_arbiter_16_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BURST = DEF_BURST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_a,
    input  logic [WIDTH-1:0] a,
    input  logic             req_b,
    input  logic [WIDTH-1:0] b,
    output logic             gnt_a,
    output logic             gnt_b,
    output logic             s,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready
);

    localparam int CNT_W = $clog2(BURST + 1);

    state_t           state;
    state_t           state_nxt;
    owner_t           last;
    owner_t           last_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] cnt_inc;
    logic             burst_done;
    logic             load_en;
    logic             gnt;
    logic [WIDTH-1:0] mux_o;

    Mux2x1_16 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a (a),
        .b (b),
        .s (s),
        .o (mux_o)
    );

    assign s       = (state == OWN_B);
    assign load_en = !o_valid || o_ready;

    // Reset masks grants so nothing is handed out in the reset cycle itself.
    assign gnt_a = !rst && (state == OWN_A) && req_a && load_en;
    assign gnt_b = !rst && (state == OWN_B) && req_b && load_en;
    assign gnt   = gnt_a || gnt_b;

    assign cnt_inc    = cnt + 1'b1;
    assign burst_done = (cnt_inc == CNT_W'(BURST));

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (req_a && req_b) begin
                    state_nxt = (last == OWNER_B) ? OWN_A : OWN_B;
                end else if (req_a) begin
                    state_nxt = OWN_A;
                end else if (req_b) begin
                    state_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    state_nxt = req_b ? OWN_B : IDLE;
                    cnt_nxt   = '0;
                    last_nxt  = OWNER_A;
                end else if (gnt_a) begin
                    if (burst_done) begin
                        // Burst exhausted: hand over only if B is waiting.
                        cnt_nxt = '0;
                        if (req_b) begin
                            state_nxt = OWN_B;
                            last_nxt  = OWNER_A;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    state_nxt = req_a ? OWN_A : IDLE;
                    cnt_nxt   = '0;
                    last_nxt  = OWNER_B;
                end else if (gnt_b) begin
                    if (burst_done) begin
                        cnt_nxt = '0;
                        if (req_a) begin
                            state_nxt = OWN_A;
                            last_nxt  = OWNER_B;
                        end
                    end else begin
                        cnt_nxt = cnt_inc;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            last    <= OWNER_B;
            cnt     <= '0;
            o       <= '0;
            o_valid <= 1'b0;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
            if (gnt) begin
                o       <= mux_o;
                o_valid <= 1'b1;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule
